// File: rtl/calc_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : calc_alu_if
// Description : Parser/formatter-facing bus of the calculator ALU.
//               master = parser side (drives request and operands),
//               slave  = calc_alu (drives status and result).
// Signals     : parser_done  start request level (master -> slave)
//               opcode[2:0]  operation select
//               src1, src2   unsigned operands, DATA_W bits
//               busy         op in flight (slave -> master)
//               calc_done    one-cycle completion pulse
//               calc_err     error flag of last completed op
//               calc_res     result, 2*DATA_W bits
// Revision    : 1.0 - initial release
// ============================================================================
interface calc_alu_if #(
  parameter int DATA_W = 16
);
  localparam int RES_W = 2 * DATA_W;

  logic              parser_done;
  logic [2:0]        opcode;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic              busy;
  logic              calc_done;
  logic              calc_err;
  logic [RES_W-1:0]  calc_res;

  modport master (
    output parser_done, opcode, src1, src2,
    input  busy, calc_done, calc_err, calc_res
  );

  modport slave (
    input  parser_done, opcode, src1, src2,
    output busy, calc_done, calc_err, calc_res
  );
endinterface
`default_nettype wire

// File: rtl/calc_alu.sv
`default_nettype none
// ============================================================================
// Module      : calc_alu
// Description : Multi-op arithmetic engine for the UART calculator. A rising
//               edge on parser_done captures opcode/src1/src2 and runs one op.
//               ADD/SUB/AND/OR/XOR/reserved finish in one EXEC cycle; MUL (and
//               DIV when enabled) iterate over DATA_W EXEC cycles.
// Ports       : clk          system clock, rising edge
//               rst          synchronous active-high reset
//               bus (slave)  parser_done/opcode/src1/src2 in,
//                            busy/calc_done/calc_err/calc_res out
// Config      : CALC_DIV_EN  defined -> opcode 6 is restoring DIV,
//                            undefined -> opcode 6 is reserved
// Revision    : 1.0 - initial release
// ============================================================================
module calc_alu #(
  parameter int DATA_W = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  calc_alu_if.slave bus
);
  localparam int RES_W = 2 * DATA_W;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [2:0] c_OP_ADD = 3'd0;
  localparam logic [2:0] c_OP_SUB = 3'd1;
  localparam logic [2:0] c_OP_MUL = 3'd2;
  localparam logic [2:0] c_OP_AND = 3'd3;
  localparam logic [2:0] c_OP_OR  = 3'd4;
  localparam logic [2:0] c_OP_XOR = 3'd5;
`ifdef CALC_DIV_EN
  localparam logic [2:0] c_OP_DIV = 3'd6;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_d1;
  logic              r_d2;
  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_a;      // operand A; dividend/quotient shifter for DIV
  logic [DATA_W-1:0] r_b;      // operand B; multiplier shifter for MUL
  logic [RES_W-1:0]  r_mcand;  // multiplicand, shifted left each MUL step
  logic [RES_W-1:0]  r_acc;    // MUL partial product
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [RES_W-1:0]  r_res;

  logic              w_start;
  logic              w_last;
  logic              w_finish;
  logic              w_err;
  logic [RES_W-1:0]  w_a_ext;
  logic [RES_W-1:0]  w_b_ext;
  logic [RES_W-1:0]  w_mul_acc;
  logic [RES_W-1:0]  w_res;

  assign w_start   = r_d1 & ~r_d2;
  assign w_last    = (r_cnt == c_CNT_LAST);
  assign w_a_ext   = {{DATA_W{1'b0}}, r_a};
  assign w_b_ext   = {{DATA_W{1'b0}}, r_b};
  assign w_mul_acc = r_acc + (r_b[0] ? r_mcand : '0);

`ifdef CALC_DIV_EN
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W:0]   w_div_shift;
  logic              w_div_ge;
  logic [DATA_W-1:0] w_rem_next;
  logic [DATA_W-1:0] w_quo_next;

  // Restoring step: bring the next dividend bit into the partial remainder
  // and subtract the divisor when it fits. The partial remainder is always
  // below the divisor, so the shifted value needs only one extra bit and the
  // difference fits back into DATA_W bits.
  assign w_div_shift = {r_rem, r_a[DATA_W-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
  assign w_rem_next  = w_div_ge ? (w_div_shift[DATA_W-1:0] - r_b)
                                : w_div_shift[DATA_W-1:0];
  assign w_quo_next  = {r_a[DATA_W-2:0], w_div_ge};
`endif

  // Result and completion of the current EXEC cycle.
  always_comb begin
    w_finish = 1'b1;
    w_err    = 1'b0;
    w_res    = '0;
    case (r_op)
      c_OP_ADD: w_res = w_a_ext + w_b_ext;
      c_OP_SUB: w_res = w_a_ext - w_b_ext;
      c_OP_MUL: begin
        w_finish = w_last;
        w_res    = w_mul_acc;
      end
      c_OP_AND: w_res = w_a_ext & w_b_ext;
      c_OP_OR:  w_res = w_a_ext | w_b_ext;
      c_OP_XOR: w_res = w_a_ext ^ w_b_ext;
`ifdef CALC_DIV_EN
      c_OP_DIV: begin
        if (r_b == '0) begin
          // Divide by zero: finish at once, remainder = dividend.
          w_res = {r_a, {DATA_W{1'b1}}};
          w_err = 1'b1;
        end else begin
          w_finish = w_last;
          w_res    = {w_rem_next, w_quo_next};
        end
      end
`endif
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_d1    <= 1'b0;
      r_d2    <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_res   <= '0;
`ifdef CALC_DIV_EN
      r_rem   <= '0;
`endif
    end else begin
      r_d1   <= bus.parser_done;
      r_d2   <= r_d1;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_op    <= bus.opcode;
            r_a     <= bus.src1;
            r_b     <= bus.src2;
            r_mcand <= {{DATA_W{1'b0}}, bus.src1};
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
`ifdef CALC_DIV_EN
            r_rem   <= '0;
`endif
            r_state <= S_EXEC;
          end
        end
        // Starts seen in EXEC or DONE are dropped, not queued.
        S_EXEC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_op == c_OP_MUL) begin
            r_acc   <= w_mul_acc;
            r_mcand <= r_mcand << 1;
            r_b     <= r_b >> 1;
          end
`ifdef CALC_DIV_EN
          if (r_op == c_OP_DIV) begin
            r_rem <= w_rem_next;
            r_a   <= w_quo_next;
          end
`endif
          if (w_finish) begin
            r_res   <= w_res;
            r_err   <= w_err;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.calc_done = r_done;
  assign bus.calc_err  = r_err;
  assign bus.calc_res  = r_res;
endmodule
`default_nettype wire

// File: tb/tb_calc_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_alu
// Description : Scoreboard bench for calc_alu. A driver issues directed and
//               random ops and queues the expected result/err/done cycle; a
//               monitor checks every calc_done pulse against the queue.
// Config      : CALC_DIV_EN selects DIV expectations for opcode 6.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_alu;
  localparam int DATA_W = 16;
  localparam int RES_W  = 2 * DATA_W;

  typedef struct {
    logic [RES_W-1:0] res;
    logic             err;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;
  logic prev_done = 1'b0;
  exp_t exp_q[$];

  calc_alu_if #(.DATA_W(DATA_W)) bus ();

  calc_alu #(.DATA_W(DATA_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the op's meaning in plain integer arithmetic. Returns {err, res}.
  function automatic logic [RES_W:0] model(input logic [2:0] op,
                                           input logic [DATA_W-1:0] a,
                                           input logic [DATA_W-1:0] b);
    longint unsigned x;
    longint unsigned y;
    longint unsigned r;
    logic            e;
    x = a;
    y = b;
    r = 0;
    e = 1'b0;
    case (op)
      3'd0: r = x + y;
      3'd1: r = x - y;
      3'd2: r = x * y;
      3'd3: r = x & y;
      3'd4: r = x | y;
      3'd5: r = x ^ y;
`ifdef CALC_DIV_EN
      3'd6: begin
        if (y == 0) begin
          r = (x << DATA_W) + 64'hFFFF;
          e = 1'b1;
        end else begin
          r = ((x % y) << DATA_W) + (x / y);
        end
      end
`endif
      default: e = 1'b1;
    endcase
    return {e, r[RES_W-1:0]};
  endfunction

  function automatic bit is_long(input logic [2:0] op, input logic [DATA_W-1:0] b);
`ifdef CALC_DIV_EN
    return (op == 3'd2) || (op == 3'd6 && b != 0);
`else
    return (op == 3'd2) || (b != b);
`endif
  endfunction

  // Monitor: every completion pulse is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (bus.calc_done === 1'b1) begin
      n_done++;
      chk("done_single_cycle", prev_done, 1'b0);
      chk("busy_with_done", bus.busy, 1'b1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got res %h err %b expected no pulse (cycle %0d)",
                 bus.calc_res, bus.calc_err, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("calc_res", bus.calc_res, e.res);
        chk("calc_err", bus.calc_err, e.err);
        chk("done_latency", cyc, e.cyc);
      end
    end
    prev_done = bus.calc_done;
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy !== 1'b0 && n < 100);
    if (bus.busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy %b expected 0", bus.busy);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Raise parser_done with fresh operands and queue the expectation.
  task automatic issue(input logic [2:0] op, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b, input bit lit,
                       input logic [RES_W-1:0] lres, input logic lerr);
    exp_t          e;
    logic [RES_W:0] m;
    bus.parser_done = 1'b0;
    wait_idle();
    @(negedge clk);
    bus.opcode      = op;
    bus.src1        = a;
    bus.src2        = b;
    bus.parser_done = 1'b1;
    m     = model(op, a, b);
    e.res = lit ? lres : m[RES_W-1:0];
    e.err = lit ? lerr : m[RES_W];
    e.cyc = cyc + (is_long(op, b) ? 2 + DATA_W : 3);
    exp_q.push_back(e);
  endtask

  // After capture: busy must be up, inputs may change freely, the held level
  // must not start a second op.
  task automatic finish_op();
    repeat (2) @(negedge clk);
    chk("busy_after_capture", bus.busy, 1'b1);
    bus.opcode = 3'($urandom);
    bus.src1   = DATA_W'($urandom);
    bus.src2   = DATA_W'($urandom);
    wait_drain();
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input logic [2:0] op, input logic [DATA_W-1:0] a,
                     input logic [DATA_W-1:0] b, input bit lit,
                     input logic [RES_W-1:0] lres, input logic lerr);
    issue(op, a, b, lit, lres, lerr);
    finish_op();
  endtask

  function automatic logic [DATA_W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return DATA_W'(1);
      default: return DATA_W'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n0;
    exp_t e;
    bus.parser_done = 1'b0;
    bus.opcode      = '0;
    bus.src1        = '0;
    bus.src2        = '0;
    rst             = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.calc_done, 1'b0);
    chk("rst_err", bus.calc_err, 1'b0);
    chk("rst_res", bus.calc_res, '0);
    rst = 1'b0;
    @(negedge clk);

    run(3'd0, 16'hFFFF, 16'h0001, 1'b1, 32'h0001_0000, 1'b0);
    run(3'd1, 16'h0003, 16'h0005, 1'b1, 32'hFFFF_FFFE, 1'b0);
    run(3'd2, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE_0001, 1'b0);
    run(3'd7, 16'h1234, 16'h5678, 1'b1, 32'h0000_0000, 1'b1);
    run(3'd0, 16'h0002, 16'h0003, 1'b1, 32'h0000_0005, 1'b0);
    run(3'd3, 16'hF0F0, 16'hFF00, 1'b1, 32'h0000_F000, 1'b0);
    run(3'd5, 16'hAAAA, 16'hFFFF, 1'b1, 32'h0000_5555, 1'b0);
`ifdef CALC_DIV_EN
    run(3'd6, 16'd100, 16'd7, 1'b1, 32'h0002_000E, 1'b0);
    run(3'd6, 16'd5, 16'd0, 1'b1, 32'h0005_FFFF, 1'b1);
    run(3'd6, 16'hFFFF, 16'h0001, 1'b1, 32'h0000_FFFF, 1'b0);
`else
    run(3'd6, 16'd100, 16'd7, 1'b1, 32'h0000_0000, 1'b1);
`endif

    // Re-toggle during MUL: second request dropped, held level does not retrigger.
    n0 = n_done;
    issue(3'd2, 16'h1234, 16'h00FF, 1'b0, '0, 1'b0);
    repeat (6) @(negedge clk);
    bus.parser_done = 1'b0;
    @(negedge clk);
    bus.parser_done = 1'b1;
    wait_drain();
    repeat (DATA_W + 6) @(negedge clk);
    chk("toggle_single_done", n_done, n0 + 1);

    // Reset mid-MUL with parser_done held through release.
    n0 = n_done;
    issue(3'd2, 16'hBEEF, 16'h0123, 1'b0, '0, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.calc_done, 1'b0);
    chk("midrst_err", bus.calc_err, 1'b0);
    chk("midrst_res", bus.calc_res, '0);
    rst   = 1'b0;
    e.res = 32'hBEEF * 32'h0123;
    e.err = 1'b0;
    e.cyc = cyc + 2 + DATA_W;
    exp_q.push_back(e);
    wait_drain();
    repeat (3) @(negedge clk);
    chk("midrst_single_done", n_done, n0 + 1);

    for (int i = 0; i < 40; i++) begin
      run(3'($urandom_range(0, 7)), pick(), pick(), 1'b0, '0, 1'b0);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
